// File: rtl/multicycle_ctrl_v2_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_v2_if #(
    parameter int unsigned OP_W = 6
);
    // Datapath status into the controller
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            mem_ready;

    // Control strobes out of the controller
    logic            alusrcA;
    logic [1:0]      alusrcB;
    logic [1:0]      aluop;
    logic            memread;
    logic            memwrite;
    logic            IorD;
    logic            IR_write;
    logic            regwrite;
    logic [1:0]      regdst;
    logic [1:0]      memtoreg;
    logic [1:0]      pcsrc;
    logic            pc_en;
    logic            illegal;
    logic            busy;
    logic [3:0]      state;

    modport master (
        input  opcode, zero, mem_ready,
        output alusrcA, alusrcB, aluop, memread, memwrite, IorD, IR_write,
               regwrite, regdst, memtoreg, pcsrc, pc_en, illegal, busy, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alusrcA, alusrcB, aluop, memread, memwrite, IorD, IR_write,
               regwrite, regdst, memtoreg, pcsrc, pc_en, illegal, busy, state
    );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control unit for a shared-memory datapath. Moore FSM with
// registered outputs; only the fetch-completion strobes (IR_write, PC write)
// and the branch PC enable are combined with live inputs.
module multicycle_ctrl_v2 #(
    parameter int unsigned OP_W          = 6,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 1,
    parameter bit          ENABLE_JAL    = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_ctrl_v2_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BEQ      = 4'd11,
        S_BNE      = 4'd12,
        S_JUMP     = 4'd13,
        S_JAL      = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);

    // A latency of 0 is meaningless; treat it as single-cycle
    localparam int unsigned      LAT      = (MEM_LAT < 1) ? 1 : MEM_LAT;
    localparam int unsigned      CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_rdy;
    logic             pc_write;

    logic             alusrcA_q;
    logic [1:0]       alusrcB_q;
    logic [1:0]       aluop_q;
    logic             memread_q;
    logic             memwrite_q;
    logic             iord_q;
    logic             regwrite_q;
    logic [1:0]       regdst_q;
    logic [1:0]       memtoreg_q;
    logic [1:0]       pcsrc_q;
    logic             illegal_q;
    logic             busy_q;
    logic             fetch_q;
    logic             pc_write_q;
    logic             pc_write_cond_q;
    logic             branch_ne_q;

    // Fixed-latency mode: the counter restarts on every state change, so each
    // memory state sees exactly LAT cycles before completing
    assign mem_rdy = MEM_HANDSHAKE ? bus.mem_ready : (wait_cnt == CNT_LAST);

    // Next-state selection from current state, opcode and memory completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = ENABLE_JAL ? S_JAL : S_ILLEGAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:    if (mem_rdy) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_ILLEGAL:
                        state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, wait counter and Moore outputs decoded from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_RESET;
            wait_cnt        <= '0;
            alusrcA_q       <= 1'b0;
            alusrcB_q       <= 2'b00;
            aluop_q         <= 2'b00;
            memread_q       <= 1'b0;
            memwrite_q      <= 1'b0;
            iord_q          <= 1'b0;
            regwrite_q      <= 1'b0;
            regdst_q        <= 2'b00;
            memtoreg_q      <= 2'b00;
            pcsrc_q         <= 2'b00;
            illegal_q       <= 1'b0;
            busy_q          <= 1'b0;
            fetch_q         <= 1'b0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            branch_ne_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt        <= (state_d != state_q) ? '0 : wait_cnt + CNT_W'(1);
            alusrcA_q       <= 1'b0;
            alusrcB_q       <= 2'b00;
            aluop_q         <= 2'b00;
            memread_q       <= 1'b0;
            memwrite_q      <= 1'b0;
            iord_q          <= 1'b0;
            regwrite_q      <= 1'b0;
            regdst_q        <= 2'b00;
            memtoreg_q      <= 2'b00;
            pcsrc_q         <= 2'b00;
            illegal_q       <= 1'b0;
            busy_q          <= (state_d != S_RESET);
            fetch_q         <= 1'b0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            branch_ne_q     <= 1'b0;
            case (state_d)
                S_FETCH: begin
                    memread_q <= 1'b1;
                    alusrcB_q <= 2'b01;
                    fetch_q   <= 1'b1;
                end
                S_DECODE: alusrcB_q <= 2'b11;
                S_MEMADR, S_ADDI_EX: begin
                    alusrcA_q <= 1'b1;
                    alusrcB_q <= 2'b10;
                end
                S_MEMRD: begin
                    memread_q <= 1'b1;
                    iord_q    <= 1'b1;
                end
                S_MEMWB: begin
                    regwrite_q <= 1'b1;
                    memtoreg_q <= 2'b01;
                end
                S_MEMWR: begin
                    memwrite_q <= 1'b1;
                    iord_q     <= 1'b1;
                end
                S_RTYPE_EX: begin
                    alusrcA_q <= 1'b1;
                    aluop_q   <= 2'b10;
                end
                S_RTYPE_WB: begin
                    regwrite_q <= 1'b1;
                    regdst_q   <= 2'b01;
                end
                S_ADDI_WB: regwrite_q <= 1'b1;
                S_BEQ, S_BNE: begin
                    alusrcA_q       <= 1'b1;
                    aluop_q         <= 2'b01;
                    pcsrc_q         <= 2'b01;
                    pc_write_cond_q <= 1'b1;
                    branch_ne_q     <= (state_d == S_BNE);
                end
                S_JUMP: begin
                    pc_write_q <= 1'b1;
                    pcsrc_q    <= 2'b10;
                end
                // PC already holds PC+4, which is the link value for $31
                S_JAL: begin
                    pc_write_q <= 1'b1;
                    pcsrc_q    <= 2'b10;
                    regwrite_q <= 1'b1;
                    regdst_q   <= 2'b10;
                    memtoreg_q <= 2'b10;
                end
                S_ILLEGAL: illegal_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Fetch completes only when memory answers, so IR/PC loads wait on mem_rdy
    assign pc_write     = pc_write_q | (fetch_q & mem_rdy);
    assign bus.IR_write = fetch_q & mem_rdy;
    assign bus.pc_en    = pc_write | (pc_write_cond_q & (bus.zero ^ branch_ne_q));

    assign bus.alusrcA  = alusrcA_q;
    assign bus.alusrcB  = alusrcB_q;
    assign bus.aluop    = aluop_q;
    assign bus.memread  = memread_q;
    assign bus.memwrite = memwrite_q;
    assign bus.IorD     = iord_q;
    assign bus.regwrite = regwrite_q;
    assign bus.regdst   = regdst_q;
    assign bus.memtoreg = memtoreg_q;
    assign bus.pcsrc    = pcsrc_q;
    assign bus.illegal  = illegal_q;
    assign bus.busy     = busy_q;
    assign bus.state    = state_q;

endmodule
